// File: rtl/btn_fltr_multi.sv
// Multi-channel push-button conditioner: 2-FF synchroniser, CE-ticked debounce,
// and registered press / release / auto-repeat event pulses per channel.
module btn_fltr_multi #(
    parameter int N          = 4,
    parameter int DB_TICKS   = 16,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit REP_EN     = 1'b1,
    parameter int REP_DLY    = 500,
    parameter int REP_PER    = 100
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CE,
    input  logic [N-1:0] BTN_I,
    output logic [N-1:0] BTN_O,
    output logic [N-1:0] BTN_PRESS,
    output logic [N-1:0] BTN_REL,
    output logic [N-1:0] BTN_REP,
    output logic         BTN_ANY
);

    localparam int DW   = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int HMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [DW-1:0] dcnt [N];
    logic [N-1:0]  accept;

    // accept: the filtered level flips on this edge (press or release)
    always_comb begin
        accept = '0;
        for (int i = 0; i < N; i++) begin
            accept[i] = CE && (s2[i] != BTN_O[i]) && (dcnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1        <= '0;
            s2        <= '0;
            BTN_O     <= '0;
            BTN_PRESS <= '0;
            BTN_REL   <= '0;
            BTN_ANY   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            s1      <= BTN_I ^ {N{ACTIVE_LOW}};
            s2      <= s1;
            BTN_ANY <= |BTN_PRESS;
            for (int i = 0; i < N; i++) begin
                BTN_PRESS[i] <= 1'b0;
                BTN_REL[i]   <= 1'b0;
                if (s2[i] == BTN_O[i]) begin
                    dcnt[i] <= '0;
                end else if (accept[i]) begin
                    BTN_O[i]     <= s2[i];
                    BTN_PRESS[i] <= s2[i];
                    BTN_REL[i]   <= ~s2[i];
                    dcnt[i]      <= '0;
                end else if (CE) begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    generate
        if (REP_EN) begin : g_rep
            localparam logic [HW-1:0] DLY_LAST = HW'(REP_DLY - 1);
            localparam logic [HW-1:0] PER_LAST = HW'(REP_PER - 1);

            logic [HW-1:0] hcnt [N];
            logic [N-1:0]  ph;

            // accept also covers release while held, which must not emit a repeat
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    ph      <= '0;
                    BTN_REP <= '0;
                    for (int i = 0; i < N; i++) begin
                        hcnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < N; i++) begin
                        BTN_REP[i] <= 1'b0;
                        if (accept[i] || !BTN_O[i]) begin
                            hcnt[i] <= '0;
                            ph[i]   <= 1'b0;
                        end else if (CE) begin
                            if (!ph[i] && (hcnt[i] == DLY_LAST)) begin
                                BTN_REP[i] <= 1'b1;
                                hcnt[i]    <= '0;
                                ph[i]      <= 1'b1;
                            end else if (ph[i] && (hcnt[i] == PER_LAST)) begin
                                BTN_REP[i] <= 1'b1;
                                hcnt[i]    <= '0;
                            end else begin
                                hcnt[i] <= hcnt[i] + 1'b1;
                            end
                        end
                    end
                end
            end
        end else begin : g_no_rep
            assign BTN_REP = '0;
        end
    endgenerate

endmodule

// File: tb/tb_btn_fltr_multi.sv
// Directed bench for btn_fltr_multi: expected event pulses are queued with their
// cycle number when stimulus is applied and compared cycle by cycle at the falling edge.
module tb_btn_fltr_multi;

    localparam int N = 2;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         CE;
    logic [N-1:0] btn_i;
    logic [N-1:0] btn_o, btn_press, btn_rel, btn_rep;
    logic         btn_any;
    logic [N-1:0] btn_i_al;
    logic [N-1:0] btn_o_al, btn_press_al, btn_rel_al, btn_rep_al;
    logic         btn_any_al;

    btn_fltr_multi #(.N(N), .DB_TICKS(4), .ACTIVE_LOW(1'b0), .REP_EN(1'b1),
                     .REP_DLY(8), .REP_PER(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .BTN_I(btn_i),
        .BTN_O(btn_o), .BTN_PRESS(btn_press), .BTN_REL(btn_rel),
        .BTN_REP(btn_rep), .BTN_ANY(btn_any)
    );

    btn_fltr_multi #(.N(N), .DB_TICKS(4), .ACTIVE_LOW(1'b1), .REP_EN(1'b1),
                     .REP_DLY(8), .REP_PER(3)) dut_al (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .BTN_I(btn_i_al),
        .BTN_O(btn_o_al), .BTN_PRESS(btn_press_al), .BTN_REL(btn_rel_al),
        .BTN_REP(btn_rep_al), .BTN_ANY(btn_any_al)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // kind: 0 press, 1 release, 2 repeat, 3 any (ch 0)
    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests  = 0;
    int  n_fail   = 0;
    int  ce_mode  = 0;
    bit  mon_en   = 1'b0;
    bit  al_watch = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input int kind, input int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    // ce_mode 0: CE always 1; 1: CE on every 4th edge (edges divisible by 4); 2: CE held 0
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            case (ce_mode)
                0:       CE = 1'b1;
                1:       CE = ((cyc % 4) == 3);
                default: CE = 1'b0;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("rst_main", {23'd0, btn_any, btn_rep, btn_rel, btn_press, btn_o}, 32'd0);
        check("rst_al", {23'd0, btn_any_al, btn_rep_al, btn_rel_al, btn_press_al, btn_o_al}, 32'd0);
        step(2);
        RST_N = 1'b1;
    endtask

    // Scoreboard: every cycle, the pulse vector must equal exactly the queued events due now.
    always @(negedge CLK) begin
        if (mon_en) begin
            logic [6:0] exp_ev;
            exp_ev = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_ev[exp_q[0].kind * 2 + exp_q[0].ch] = 1'b1;
                void'(exp_q.pop_front());
            end
            check("events", {25'd0, btn_any, btn_rep, btn_rel, btn_press}, {25'd0, exp_ev});
        end
        if (al_watch) begin
            check("al_idle", {23'd0, btn_any_al, btn_rep_al, btn_rel_al, btn_press_al, btn_o_al}, 32'd0);
        end
    end

    initial begin
        int c;
        RST_N    = 1'b1;
        CE       = 1'b1;
        btn_i    = 2'b00;
        btn_i_al = 2'b11;

        // Reset state
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("rst_main", {23'd0, btn_any, btn_rep, btn_rel, btn_press, btn_o}, 32'd0);
        check("rst_al", {23'd0, btn_any_al, btn_rep_al, btn_rel_al, btn_press_al, btn_o_al}, 32'd0);
        mon_en   = 1'b1;
        al_watch = 1'b1;
        step(2);
        RST_N = 1'b1;
        step(2);

        // Clean press, auto-repeat, release while repeating
        c = cyc;
        btn_i = 2'b01;
        expect_ev(c + 6, 0, 0);
        expect_ev(c + 7, 3, 0);
        expect_ev(c + 14, 2, 0);
        expect_ev(c + 17, 2, 0);
        expect_ev(c + 20, 2, 0);
        expect_ev(c + 23, 2, 0);
        expect_ev(c + 26, 1, 0);
        step(5);
        check("press_lat_before", {30'd0, btn_o}, 32'd0);
        step(1);
        check("press_lat_at", {30'd0, btn_o}, 32'd1);
        step(14);
        btn_i = 2'b00;
        step(5);
        check("rel_before", {30'd0, btn_o}, 32'd1);
        step(1);
        check("rel_at", {30'd0, btn_o}, 32'd0);
        step(6);

        // Glitch of 3 cycles rejected
        btn_i = 2'b10;
        step(3);
        btn_i = 2'b00;
        step(8);
        check("glitch3_o", {30'd0, btn_o}, 32'd0);

        // 4-cycle high accepted, then released
        c = cyc;
        btn_i = 2'b10;
        expect_ev(c + 6, 0, 1);
        expect_ev(c + 7, 3, 0);
        expect_ev(c + 10, 1, 1);
        step(4);
        btn_i = 2'b00;
        step(2);
        check("pulse4_o", {30'd0, btn_o}, 32'd2);
        step(5);
        check("pulse4_rel_o", {30'd0, btn_o}, 32'd0);

        // CE every 4th edge
        ce_mode = 1;
        while ((cyc % 4) != 0) step(1);
        c = cyc;
        btn_i = 2'b01;
        expect_ev(c + 16, 0, 0);
        expect_ev(c + 17, 3, 0);
        step(15);
        check("ce_gate_before", {30'd0, btn_o}, 32'd0);
        step(1);
        check("ce_gate_at", {30'd0, btn_o}, 32'd1);
        ce_mode = 2;
        CE = 1'b0;
        btn_i = 2'b10;
        step(30);
        check("ce_frozen_o", {30'd0, btn_o}, 32'd1);

        ce_mode = 0;
        btn_i = 2'b00;
        do_reset();
        step(2);

        // Asynchronous reset while in repeat phase
        c = cyc;
        btn_i = 2'b01;
        expect_ev(c + 6, 0, 0);
        expect_ev(c + 7, 3, 0);
        expect_ev(c + 14, 2, 0);
        expect_ev(c + 17, 2, 0);
        step(18);
        check("hold_o", {30'd0, btn_o}, 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst", {23'd0, btn_any, btn_rep, btn_rel, btn_press, btn_o}, 32'd0);
        step(2);
        RST_N = 1'b1;
        c = cyc;
        expect_ev(c + 6, 0, 0);
        expect_ev(c + 7, 3, 0);
        step(5);
        check("rerst_before", {30'd0, btn_o}, 32'd0);
        step(1);
        check("rerst_at", {30'd0, btn_o}, 32'd1);
        step(2);
        btn_i = 2'b00;
        do_reset();
        step(2);

        // Active-low instance: simultaneous press on both channels
        al_watch = 1'b0;
        c = cyc;
        btn_i_al = 2'b00;
        step(5);
        check("al_press_before", {30'd0, btn_press_al}, 32'd0);
        step(1);
        check("al_press_at", {30'd0, btn_press_al}, 32'd3);
        check("al_o_at", {30'd0, btn_o_al}, 32'd3);
        check("al_any_pre", {31'd0, btn_any_al}, 32'd0);
        step(1);
        check("al_any_at", {31'd0, btn_any_al}, 32'd1);
        check("al_press_after", {30'd0, btn_press_al}, 32'd0);
        step(3);

        check("queue_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
